// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   Architectural register storage: 32 integer and 32 float registers.
//   Three combinational read ports feed the operand muxes. Four write-back
//   ports (misc, alu, mem, fpu) update the banks on the rising clock edge.
//   Integer r0 is hard-wired to zero. Float f0 is an ordinary register.
//
//   Optional build macro: RF_WRITE_THROUGH_EN
//     defined   : read ports bypass same-cycle writes (highest priority wins)
//     undefined : read ports return stored contents only
//
// Ports
//   clk                     in   1   clock; all writes on rising edge
//   reset                   in   1   asynchronous, active-high; clears banks
//   read_addr_a/b/c         in   5   read index
//   read_float_a/b/c        in   1   1 = float bank, 0 = integer bank
//   read_data_a/b/c         out  32  read data
//   write_enable_<u>        in   1   write request, u in {misc,alu,mem,fpu}
//   write_addr_<u>          in   5   destination index
//   write_data_<u>          in   32  write data
//   write_float_<u>         in   1   1 = float bank, 0 = integer bank
// ---------------------------------------------------------------------------
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] read_addr_a,
   input  logic [ADDR_WIDTH-1:0] read_addr_b,
   input  logic [ADDR_WIDTH-1:0] read_addr_c,
   input  logic                  read_float_a,
   input  logic                  read_float_b,
   input  logic                  read_float_c,
   output logic [DATA_WIDTH-1:0] read_data_a,
   output logic [DATA_WIDTH-1:0] read_data_b,
   output logic [DATA_WIDTH-1:0] read_data_c,
   input  logic                  write_enable_misc,
   input  logic [ADDR_WIDTH-1:0] write_addr_misc,
   input  logic [DATA_WIDTH-1:0] write_data_misc,
   input  logic                  write_float_misc,
   input  logic                  write_enable_alu,
   input  logic [ADDR_WIDTH-1:0] write_addr_alu,
   input  logic [DATA_WIDTH-1:0] write_data_alu,
   input  logic                  write_float_alu,
   input  logic                  write_enable_mem,
   input  logic [ADDR_WIDTH-1:0] write_addr_mem,
   input  logic [DATA_WIDTH-1:0] write_data_mem,
   input  logic                  write_float_mem,
   input  logic                  write_enable_fpu,
   input  logic [ADDR_WIDTH-1:0] write_addr_fpu,
   input  logic [DATA_WIDTH-1:0] write_data_fpu,
   input  logic                  write_float_fpu
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_int_regs   [NUM_REGS];
   logic [DATA_WIDTH-1:0] r_float_regs [NUM_REGS];

   logic [ADDR_WIDTH-1:0] w_rd_addr  [3];
   logic                  w_rd_float [3];
   logic [DATA_WIDTH-1:0] w_rd_data  [3];

   // Units are applied lowest priority first so the later non-blocking
   // assignment (misc) wins a same-bank, same-address collision, matching
   // the forwarding network where misc is the last stage to override.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_int_regs[i]   <= '0;
            r_float_regs[i] <= '0;
         end
      end else begin
         if (write_enable_fpu) begin
            if (write_float_fpu)
               r_float_regs[write_addr_fpu] <= write_data_fpu;
            else if (write_addr_fpu != '0)
               r_int_regs[write_addr_fpu] <= write_data_fpu;
         end
         if (write_enable_mem) begin
            if (write_float_mem)
               r_float_regs[write_addr_mem] <= write_data_mem;
            else if (write_addr_mem != '0)
               r_int_regs[write_addr_mem] <= write_data_mem;
         end
         if (write_enable_alu) begin
            if (write_float_alu)
               r_float_regs[write_addr_alu] <= write_data_alu;
            else if (write_addr_alu != '0)
               r_int_regs[write_addr_alu] <= write_data_alu;
         end
         if (write_enable_misc) begin
            if (write_float_misc)
               r_float_regs[write_addr_misc] <= write_data_misc;
            else if (write_addr_misc != '0)
               r_int_regs[write_addr_misc] <= write_data_misc;
         end
      end
   end

   function automatic logic [DATA_WIDTH-1:0] f_read(
      input logic                  i_float,
      input logic [ADDR_WIDTH-1:0] i_addr
   );
      logic [DATA_WIDTH-1:0] v;
      v = i_float ? r_float_regs[i_addr] : r_int_regs[i_addr];
`ifdef RF_WRITE_THROUGH_EN
      // Same precedence as the write path: last match checked wins.
      if (write_enable_fpu && (write_float_fpu == i_float) && (write_addr_fpu == i_addr))
         v = write_data_fpu;
      if (write_enable_mem && (write_float_mem == i_float) && (write_addr_mem == i_addr))
         v = write_data_mem;
      if (write_enable_alu && (write_float_alu == i_float) && (write_addr_alu == i_addr))
         v = write_data_alu;
      if (write_enable_misc && (write_float_misc == i_float) && (write_addr_misc == i_addr))
         v = write_data_misc;
`endif
      if (!i_float && (i_addr == '0))
         v = '0;
      return v;
   endfunction

   assign w_rd_addr[0]  = read_addr_a;
   assign w_rd_addr[1]  = read_addr_b;
   assign w_rd_addr[2]  = read_addr_c;
   assign w_rd_float[0] = read_float_a;
   assign w_rd_float[1] = read_float_b;
   assign w_rd_float[2] = read_float_c;

   // Outputs are forced to zero during reset so a bypassed write cannot
   // leak through while the banks are being cleared.
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         w_rd_data[p] = reset ? '0 : f_read(w_rd_float[p], w_rd_addr[p]);
      end
   end

   assign read_data_a = w_rd_data[0];
   assign read_data_b = w_rd_data[1];
   assign read_data_c = w_rd_data[2];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

   logic        clk;
   logic        reset;
   logic [4:0]  read_addr_a, read_addr_b, read_addr_c;
   logic        read_float_a, read_float_b, read_float_c;
   logic [31:0] read_data_a, read_data_b, read_data_c;
   logic        write_enable_misc, write_enable_alu, write_enable_mem, write_enable_fpu;
   logic [4:0]  write_addr_misc, write_addr_alu, write_addr_mem, write_addr_fpu;
   logic [31:0] write_data_misc, write_data_alu, write_data_mem, write_data_fpu;
   logic        write_float_misc, write_float_alu, write_float_mem, write_float_fpu;

   int total = 0;
   int bad   = 0;

`ifdef RF_WRITE_THROUGH_EN
   localparam bit WT = 1'b1;
`else
   localparam bit WT = 1'b0;
`endif

   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk               (clk),
      .reset             (reset),
      .read_addr_a       (read_addr_a),
      .read_addr_b       (read_addr_b),
      .read_addr_c       (read_addr_c),
      .read_float_a      (read_float_a),
      .read_float_b      (read_float_b),
      .read_float_c      (read_float_c),
      .read_data_a       (read_data_a),
      .read_data_b       (read_data_b),
      .read_data_c       (read_data_c),
      .write_enable_misc (write_enable_misc),
      .write_addr_misc   (write_addr_misc),
      .write_data_misc   (write_data_misc),
      .write_float_misc  (write_float_misc),
      .write_enable_alu  (write_enable_alu),
      .write_addr_alu    (write_addr_alu),
      .write_data_alu    (write_data_alu),
      .write_float_alu   (write_float_alu),
      .write_enable_mem  (write_enable_mem),
      .write_addr_mem    (write_addr_mem),
      .write_data_mem    (write_data_mem),
      .write_float_mem   (write_float_mem),
      .write_enable_fpu  (write_enable_fpu),
      .write_addr_fpu    (write_addr_fpu),
      .write_data_fpu    (write_data_fpu),
      .write_float_fpu   (write_float_fpu)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic clear_writes();
      write_enable_misc = 0; write_enable_alu = 0; write_enable_mem = 0; write_enable_fpu = 0;
      write_addr_misc = 0;   write_addr_alu = 0;   write_addr_mem = 0;   write_addr_fpu = 0;
      write_data_misc = 0;   write_data_alu = 0;   write_data_mem = 0;   write_data_fpu = 0;
      write_float_misc = 0;  write_float_alu = 0;  write_float_mem = 0;  write_float_fpu = 0;
   endtask

   task automatic set_reads(input logic fa, input logic [4:0] aa,
                            input logic fb, input logic [4:0] ab,
                            input logic fc, input logic [4:0] ac);
      read_float_a = fa; read_addr_a = aa;
      read_float_b = fb; read_addr_b = ab;
      read_float_c = fc; read_addr_c = ac;
   endtask

   // Clock the pending writes in, then drop all enables before sampling.
   task automatic step();
      @(posedge clk);
      #1;
      clear_writes();
      #1;
   endtask

   task automatic test_reset();
      set_reads(0, 5'd3, 1, 5'd3, 1, 5'd0);
      #1;
      total++;
      if (read_data_a !== 32'h0 || read_data_b !== 32'h0 || read_data_c !== 32'h0) begin
         bad++;
         $display("FAIL reset_hold: got a=%h b=%h c=%h expected all 0", read_data_a, read_data_b, read_data_c);
      end
      @(negedge clk);
      reset = 0;
      #1;
      write_enable_misc = 1; write_addr_misc = 5'd1; write_data_misc = 32'h11; write_float_misc = 0;
      write_enable_fpu  = 1; write_addr_fpu  = 5'd1; write_data_fpu  = 32'h22; write_float_fpu  = 1;
      step();
      set_reads(0, 5'd1, 1, 5'd1, 0, 5'd0);
      #1;
      total++;
      if (read_data_a !== 32'h11) begin
         bad++; $display("FAIL pre_reset_int: got %h expected %h", read_data_a, 32'h11);
      end
      total++;
      if (read_data_b !== 32'h22) begin
         bad++; $display("FAIL pre_reset_float: got %h expected %h", read_data_b, 32'h22);
      end
      // Pulse reset between clock edges.
      #2 reset = 1;
      #2 reset = 0;
      #1;
      for (int i = 0; i < 32; i++) begin
         set_reads(0, 5'(i), 1, 5'(i), (i % 2) == 1, 5'(31 - i));
         #1;
         total++;
         if (read_data_a !== 32'h0) begin
            bad++; $display("FAIL sweep_int_%0d: got %h expected 0", i, read_data_a);
         end
         total++;
         if (read_data_b !== 32'h0) begin
            bad++; $display("FAIL sweep_float_%0d: got %h expected 0", i, read_data_b);
         end
         total++;
         if (read_data_c !== 32'h0) begin
            bad++; $display("FAIL sweep_c_%0d: got %h expected 0", i, read_data_c);
         end
      end
   endtask

   task automatic test_bank_separation();
      write_enable_alu = 1; write_addr_alu = 5'd5; write_data_alu = 32'h12345678; write_float_alu = 0;
      write_enable_fpu = 1; write_addr_fpu = 5'd5; write_data_fpu = 32'h3F800000; write_float_fpu = 1;
      step();
      set_reads(0, 5'd5, 1, 5'd5, 0, 5'd6);
      #1;
      total++;
      if (read_data_a !== 32'h12345678) begin
         bad++; $display("FAIL bank_int5: got %h expected %h", read_data_a, 32'h12345678);
      end
      total++;
      if (read_data_b !== 32'h3F800000) begin
         bad++; $display("FAIL bank_float5: got %h expected %h", read_data_b, 32'h3F800000);
      end
      total++;
      if (read_data_c !== 32'h0) begin
         bad++; $display("FAIL bank_int6_untouched: got %h expected 0", read_data_c);
      end
   endtask

   task automatic test_zero_register();
      write_enable_misc = 1; write_addr_misc = 5'd0; write_data_misc = 32'hFFFFFFFF; write_float_misc = 0;
      set_reads(0, 5'd0, 0, 5'd0, 0, 5'd0);
      #1;
      total++;
      if (read_data_a !== 32'h0) begin
         bad++; $display("FAIL r0_same_cycle: got %h expected 0", read_data_a);
      end
      step();
      total++;
      if (read_data_a !== 32'h0) begin
         bad++; $display("FAIL r0_after_write: got %h expected 0", read_data_a);
      end
      write_enable_mem = 1; write_addr_mem = 5'd0; write_data_mem = 32'hDEADBEEF; write_float_mem = 1;
      step();
      set_reads(1, 5'd0, 0, 5'd0, 1, 5'd0);
      #1;
      total++;
      if (read_data_a !== 32'hDEADBEEF) begin
         bad++; $display("FAIL f0_write: got %h expected %h", read_data_a, 32'hDEADBEEF);
      end
      total++;
      if (read_data_b !== 32'h0) begin
         bad++; $display("FAIL r0_vs_f0: got %h expected 0", read_data_b);
      end
   endtask

   task automatic test_collision();
      write_enable_misc = 1; write_addr_misc = 5'd7; write_data_misc = 32'd1; write_float_misc = 0;
      write_enable_alu  = 1; write_addr_alu  = 5'd7; write_data_alu  = 32'd2; write_float_alu  = 0;
      write_enable_mem  = 1; write_addr_mem  = 5'd7; write_data_mem  = 32'd3; write_float_mem  = 0;
      write_enable_fpu  = 1; write_addr_fpu  = 5'd7; write_data_fpu  = 32'd4; write_float_fpu  = 0;
      step();
      set_reads(0, 5'd7, 1, 5'd7, 0, 5'd7);
      #1;
      total++;
      if (read_data_a !== 32'd1) begin
         bad++; $display("FAIL collide_all4: got %h expected %h", read_data_a, 32'd1);
      end
      total++;
      if (read_data_b !== 32'd0) begin
         bad++; $display("FAIL collide_float7_untouched: got %h expected 0", read_data_b);
      end
      write_enable_alu = 1; write_addr_alu = 5'd7; write_data_alu = 32'd2; write_float_alu = 0;
      write_enable_mem = 1; write_addr_mem = 5'd7; write_data_mem = 32'd3; write_float_mem = 0;
      write_enable_fpu = 1; write_addr_fpu = 5'd7; write_data_fpu = 32'd4; write_float_fpu = 0;
      step();
      total++;
      if (read_data_a !== 32'd2) begin
         bad++; $display("FAIL collide_no_misc: got %h expected %h", read_data_a, 32'd2);
      end
      write_enable_mem = 1; write_addr_mem = 5'd7; write_data_mem = 32'd3; write_float_mem = 0;
      write_enable_fpu = 1; write_addr_fpu = 5'd7; write_data_fpu = 32'd4; write_float_fpu = 0;
      step();
      total++;
      if (read_data_a !== 32'd3) begin
         bad++; $display("FAIL collide_mem_fpu: got %h expected %h", read_data_a, 32'd3);
      end
   endtask

   task automatic test_cross_bank_and_parallel();
      write_enable_misc = 1; write_addr_misc = 5'd12; write_data_misc = 32'hAA; write_float_misc = 0;
      write_enable_alu  = 1; write_addr_alu  = 5'd12; write_data_alu  = 32'hBB; write_float_alu  = 1;
      step();
      set_reads(0, 5'd12, 1, 5'd12, 0, 5'd0);
      #1;
      total++;
      if (read_data_a !== 32'hAA) begin
         bad++; $display("FAIL cross_int12: got %h expected %h", read_data_a, 32'hAA);
      end
      total++;
      if (read_data_b !== 32'hBB) begin
         bad++; $display("FAIL cross_float12: got %h expected %h", read_data_b, 32'hBB);
      end
      write_enable_misc = 1; write_addr_misc = 5'd20; write_data_misc = 32'h101; write_float_misc = 0;
      write_enable_alu  = 1; write_addr_alu  = 5'd21; write_data_alu  = 32'h202; write_float_alu  = 0;
      write_enable_mem  = 1; write_addr_mem  = 5'd22; write_data_mem  = 32'h303; write_float_mem  = 1;
      write_enable_fpu  = 1; write_addr_fpu  = 5'd31; write_data_fpu  = 32'h404; write_float_fpu  = 1;
      step();
      set_reads(0, 5'd20, 0, 5'd21, 1, 5'd22);
      #1;
      total++;
      if (read_data_a !== 32'h101) begin
         bad++; $display("FAIL par_int20: got %h expected %h", read_data_a, 32'h101);
      end
      total++;
      if (read_data_b !== 32'h202) begin
         bad++; $display("FAIL par_int21: got %h expected %h", read_data_b, 32'h202);
      end
      total++;
      if (read_data_c !== 32'h303) begin
         bad++; $display("FAIL par_float22: got %h expected %h", read_data_c, 32'h303);
      end
      set_reads(1, 5'd31, 0, 5'd31, 1, 5'd20);
      #1;
      total++;
      if (read_data_a !== 32'h404) begin
         bad++; $display("FAIL par_float31: got %h expected %h", read_data_a, 32'h404);
      end
      total++;
      if (read_data_b !== 32'h0 || read_data_c !== 32'h0) begin
         bad++; $display("FAIL par_neighbours: got b=%h c=%h expected 0", read_data_b, read_data_c);
      end
   endtask

   task automatic test_x_addr_disabled();
      write_enable_misc = 0; write_addr_misc = 'x; write_data_misc = 32'hBAD0BAD0; write_float_misc = 'x;
      write_enable_alu  = 0; write_addr_alu  = 'x; write_data_alu  = 'x;
      @(posedge clk);
      #1;
      clear_writes();
      set_reads(0, 5'd5, 1, 5'd5, 0, 5'd12);
      #1;
      total++;
      if (read_data_a !== 32'h12345678 || read_data_b !== 32'h3F800000 || read_data_c !== 32'hAA) begin
         bad++;
         $display("FAIL x_addr_disabled: got a=%h b=%h c=%h expected 12345678 3f800000 000000aa",
                  read_data_a, read_data_b, read_data_c);
      end
   endtask

   task automatic test_write_timing();
      set_reads(0, 5'd3, 0, 5'd0, 0, 5'd0);
      write_enable_alu = 1; write_addr_alu = 5'd3; write_data_alu = 32'hA5A5A5A5; write_float_alu = 0;
      #1;
      total++;
      if (read_data_a !== (WT ? 32'hA5A5A5A5 : 32'h0)) begin
         bad++;
         $display("FAIL timing_same_cycle: got %h expected %h", read_data_a, (WT ? 32'hA5A5A5A5 : 32'h0));
      end
      step();
      total++;
      if (read_data_a !== 32'hA5A5A5A5) begin
         bad++; $display("FAIL timing_next_cycle: got %h expected %h", read_data_a, 32'hA5A5A5A5);
      end
   endtask

   task automatic test_back_to_back();
      set_reads(0, 5'd10, 0, 5'd0, 0, 5'd0);
      write_enable_mem = 1; write_addr_mem = 5'd10; write_data_mem = 32'h1; write_float_mem = 0;
      @(posedge clk);
      #1;
      write_data_mem = 32'h2;
      #1;
      total++;
      if (read_data_a !== (WT ? 32'h2 : 32'h1)) begin
         bad++; $display("FAIL b2b_first: got %h expected %h", read_data_a, (WT ? 32'h2 : 32'h1));
      end
      step();
      total++;
      if (read_data_a !== 32'h2) begin
         bad++; $display("FAIL b2b_second: got %h expected %h", read_data_a, 32'h2);
      end
   endtask

   task automatic test_reset_mid_operation();
      set_reads(0, 5'd9, 0, 5'd3, 1, 5'd0);
      write_enable_alu = 1; write_addr_alu = 5'd9; write_data_alu = 32'h55; write_float_alu = 0;
      @(posedge clk);
      #2;
      total++;
      if (read_data_a !== 32'h55) begin
         bad++; $display("FAIL midrst_before: got %h expected %h", read_data_a, 32'h55);
      end
      reset = 1;
      #1;
      total++;
      if (read_data_a !== 32'h0 || read_data_b !== 32'h0 || read_data_c !== 32'h0) begin
         bad++;
         $display("FAIL midrst_immediate: got a=%h b=%h c=%h expected all 0", read_data_a, read_data_b, read_data_c);
      end
      @(posedge clk);
      #1;
      total++;
      if (read_data_a !== 32'h0) begin
         bad++; $display("FAIL midrst_write_ignored: got %h expected 0", read_data_a);
      end
      #2 reset = 0;
      #1;
      total++;
      if (read_data_a !== (WT ? 32'h55 : 32'h0) || read_data_b !== 32'h0) begin
         bad++;
         $display("FAIL midrst_released: got a=%h b=%h expected %h 0", read_data_a, read_data_b,
                  (WT ? 32'h55 : 32'h0));
      end
      step();
      total++;
      if (read_data_a !== 32'h55) begin
         bad++; $display("FAIL midrst_first_write: got %h expected %h", read_data_a, 32'h55);
      end
   endtask

   initial begin
      reset = 1;
      clear_writes();
      set_reads(0, 5'd0, 0, 5'd0, 0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_bank_separation();
      test_zero_register();
      test_collision();
      test_cross_bank_and_parallel();
      test_x_addr_disabled();
      test_write_timing();
      test_back_to_back();
      test_reset_mid_operation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
